// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler: multi-zone irrigation controller.
// Sensors are synchronised and debounced, dry zones are served one at a time
// in round-robin order, and each run is followed by a fixed cooldown.
// Build option: define ALARM_BLINK_EN to make the alarm blink with half-period
// BLINK_CYCLES while the alarm condition holds (default: steady level).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a dry zone while usable water is available
// RUN      | one zone actuator driven, run counter bounds the run length
// COOLDOWN | all zone actuators off, fixed pause before the next pick
// FAULT    | tank sensors disagree; zones and valve off until they agree

module irrigation_scheduler #(
    parameter int ZONES           = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_RUN_CYCLES  = 16,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int BLINK_CYCLES    = 8,
    localparam int AZW            = (ZONES > 1) ? $clog2(ZONES) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             low_water_level,
    input  logic             mid_water_level,
    input  logic             high_water_level,
    input  logic [ZONES-1:0] earth_humidity,
    input  logic             air_humidity,
    input  logic             low_temperature,
    output logic             water_supply_valvule,
    output logic [ZONES-1:0] zone_splinker,
    output logic [ZONES-1:0] zone_dripper,
    output logic [AZW-1:0]   active_zone,
    output logic [1:0]       state,
    output logic             timeout_pulse,
    output logic             alarm
);

    localparam int NS    = ZONES + 5;
    localparam int DBW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int CMAX0 = (MAX_RUN_CYCLES > COOLDOWN_CYCLES) ? MAX_RUN_CYCLES : COOLDOWN_CYCLES;
    localparam int CMAX  = (CMAX0 > DEBOUNCE_CYCLES) ? CMAX0 : DEBOUNCE_CYCLES;
    localparam int CW    = (CMAX > 1) ? $clog2(CMAX) : 1;

    // sensor bit positions inside the conditioned vector
    localparam int SI_LOW   = 0;
    localparam int SI_MID   = 1;
    localparam int SI_HIGH  = 2;
    localparam int SI_AIR   = 3;
    localparam int SI_LTEMP = 4;
    localparam int SI_EARTH = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_COOL  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    logic [NS-1:0]  raw;
    logic [NS-1:0]  sync1_q, sync1_d;
    logic [NS-1:0]  sync2_q, sync2_d;
    logic [NS-1:0]  deb_q, deb_d;
    logic [DBW-1:0] db_cnt_q [NS];
    logic [DBW-1:0] db_cnt_d [NS];

    assign raw = {earth_humidity, low_temperature, air_humidity,
                  high_water_level, mid_water_level, low_water_level};

    // Synchroniser stages and per-bit debounce counters.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        for (int i = 0; i < NS; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Register the input conditioning path.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            for (int i = 0; i < NS; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            for (int i = 0; i < NS; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    logic             low_db, mid_db, high_db, air_db, ltemp_db;
    logic [ZONES-1:0] request;
    logic             conflict, water_ok, sprinkler_now;

    assign low_db        = deb_q[SI_LOW];
    assign mid_db        = deb_q[SI_MID];
    assign high_db       = deb_q[SI_HIGH];
    assign air_db        = deb_q[SI_AIR];
    assign ltemp_db      = deb_q[SI_LTEMP];
    assign request       = ~deb_q[NS-1:SI_EARTH];
    assign conflict      = (high_db & ~mid_db) | (mid_db & ~low_db);
    assign water_ok      = low_db & ~conflict;
    assign sprinkler_now = mid_db & ~air_db & ~ltemp_db;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AZW-1:0]   active_zone_q, active_zone_d;
    logic             mode_spk_q, mode_spk_d;
    logic             timeout_q, timeout_d;
    logic [ZONES-1:0] spk_q, spk_d;
    logic [ZONES-1:0] drp_q, drp_d;
    logic             valve_q, valve_d;
    logic             alarm_q, alarm_d;
    logic             alarm_cond;
    logic [AZW-1:0]   pick;
    logic             found;
    logic [ZONES-1:0] az_onehot;
    logic             run_on;
    int               idx;

    // Round-robin pick: nearest requesting zone after active_zone, itself last.
    always_comb begin
        pick  = active_zone_q;
        found = 1'b0;
        idx   = 0;
        for (int i = ZONES; i >= 1; i--) begin
            idx = int'(active_zone_q) + i;
            if (idx >= ZONES) idx = idx - ZONES;
            if (request[idx]) begin
                pick  = AZW'(idx);
                found = 1'b1;
            end
        end
    end

    // Next state, shared run/cooldown/fault counter, and registered outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        active_zone_d = active_zone_q;
        mode_spk_d    = mode_spk_q;
        timeout_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (conflict) begin
                    state_d = S_FAULT;
                    cnt_d   = '0;
                end else if (water_ok && found) begin
                    state_d       = S_RUN;
                    active_zone_d = pick;
                    mode_spk_d    = sprinkler_now;
                    cnt_d         = '0;
                end
            end
            S_RUN: begin
                if (conflict) begin
                    state_d = S_FAULT;
                    cnt_d   = '0;
                end else if (!request[active_zone_q] || !water_ok ||
                             cnt_q == CW'(MAX_RUN_CYCLES - 1)) begin
                    state_d   = S_COOL;
                    cnt_d     = '0;
                    timeout_d = (cnt_q == CW'(MAX_RUN_CYCLES - 1));
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_COOL: begin
                if (conflict) begin
                    state_d = S_FAULT;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(COOLDOWN_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (conflict) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        az_onehot                = '0;
        az_onehot[active_zone_q] = 1'b1;
        // a conflict blanks the actuators in the same edge that enters FAULT
        run_on     = (state_q == S_RUN) && !conflict;
        spk_d      = (run_on &&  mode_spk_q) ? az_onehot : '0;
        drp_d      = (run_on && !mode_spk_q) ? az_onehot : '0;
        valve_d    = ~conflict & ~high_db & (state_q != S_FAULT);
        alarm_cond = (state_d == S_FAULT) | (~mid_db & ~conflict);
    end

`ifdef ALARM_BLINK_EN
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;

    // Blink starts high and toggles every BLINK_CYCLES while the condition holds.
    always_comb begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b0;
        alarm_d     = 1'b0;
        if (alarm_cond) begin
            blink_on_d = 1'b1;
            if (!blink_on_q) begin
                alarm_d = 1'b1;
            end else if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
                alarm_d = ~alarm_q;
            end else begin
                alarm_d     = alarm_q;
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Register the blink timer.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end
`else
    // Steady alarm level.
    always_comb begin
        alarm_d = alarm_cond;
    end
`endif

    // FSM state, counter and all registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            active_zone_q <= AZW'(ZONES - 1);
            mode_spk_q    <= 1'b0;
            timeout_q     <= 1'b0;
            spk_q         <= '0;
            drp_q         <= '0;
            valve_q       <= 1'b0;
            alarm_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            active_zone_q <= active_zone_d;
            mode_spk_q    <= mode_spk_d;
            timeout_q     <= timeout_d;
            spk_q         <= spk_d;
            drp_q         <= drp_d;
            valve_q       <= valve_d;
            alarm_q       <= alarm_d;
        end
    end

    assign water_supply_valvule = valve_q;
    assign zone_splinker        = spk_q;
    assign zone_dripper         = drp_q;
    assign active_zone          = active_zone_q;
    assign state                = state_q;
    assign timeout_pulse        = timeout_q;
    assign alarm                = alarm_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed bench for irrigation_scheduler with a run scoreboard.
module tb_irrigation_scheduler;

    localparam int ZONES = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       low, mid, high, air, ltemp;
    logic [3:0] earth;
    logic       valve, timeout_pulse, alarm;
    logic [3:0] zone_splinker, zone_dripper;
    logic [1:0] active_zone, state;

    irrigation_scheduler #(
        .ZONES(ZONES), .DEBOUNCE_CYCLES(4), .MAX_RUN_CYCLES(16),
        .COOLDOWN_CYCLES(8), .BLINK_CYCLES(8)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .low_water_level(low), .mid_water_level(mid), .high_water_level(high),
        .earth_humidity(earth), .air_humidity(air), .low_temperature(ltemp),
        .water_supply_valvule(valve), .zone_splinker(zone_splinker),
        .zone_dripper(zone_dripper), .active_zone(active_zone), .state(state),
        .timeout_pulse(timeout_pulse), .alarm(alarm)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] spk;
        logic [3:0] drp;
        logic [1:0] az;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         tp_count = 0;
    logic [3:0] mon_act;
    logic [3:0] prev_act = 4'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(state), 32'(s));
    endtask

    task automatic wait_act(input logic [3:0] spk, input logic [3:0] drp,
                            input int budget, input string tag);
        int n = 0;
        while (!(zone_splinker === spk && zone_dripper === drp) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'({zone_splinker, zone_dripper}), 32'({spk, drp}));
    endtask

    // Monitor: one-hot actuators, timeout pulse count, run-start scoreboard.
    always @(negedge clock) begin
        if (timeout_pulse === 1'b1) tp_count++;
        mon_act = zone_splinker | zone_dripper;
        if (mon_act != 4'd0) begin
            check("act_onehot", 32'($onehot(mon_act) && ((zone_splinker & zone_dripper) == 4'd0)), 32'd1);
            if (prev_act == 4'd0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_run", 32'(mon_act), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_spk", 32'(zone_splinker), 32'(mon_e.spk));
                    check("sb_drp", 32'(zone_dripper), 32'(mon_e.drp));
                    check("sb_zone", 32'(active_zone), 32'(mon_e.az));
                end
            end
        end
        prev_act = mon_act;
    end

    initial begin
        int n;
        int tp0;
        reset_n = 1'b0;
        low = 1'b1; mid = 1'b1; high = 1'b1;
        earth = 4'hF; air = 1'b1; ltemp = 1'b0;
        tick(3);
        reset_n = 1'b1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_zones", 32'(zone_splinker | zone_dripper), 32'd0);
        check("rst_valve", 32'(valve), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_az", 32'(active_zone), 32'd3);
        check("rst_tp", 32'(timeout_pulse), 32'd0);

        // full tank, all wet, humid air
        tick(12);
        check("full_state", 32'(state), 32'd0);
        check("full_valve", 32'(valve), 32'd0);
        check("full_alarm", 32'(alarm), 32'd0);
        check("full_zones", 32'(zone_splinker | zone_dripper), 32'd0);

        // zones 1 and 3 dry, dry warm air: sprinkler, zone 1 then zone 3
        air = 1'b0;
        earth = 4'b0101;
        exp_q.push_back('{spk: 4'b0010, drp: 4'b0000, az: 2'd1});
        exp_q.push_back('{spk: 4'b1000, drp: 4'b0000, az: 2'd3});
        wait_act(4'b0010, 4'b0000, 20, "run_zone1");
        earth[1] = 1'b1;
        wait_state(2'd2, 20, "cool_after_zone1");
        n = 0;
        while (state === 2'd2 && n < 20) begin
            tick(1);
            n++;
        end
        check("cool_len", 32'(n), 32'd8);
        wait_act(4'b1000, 4'b0000, 10, "run_zone3");
        earth[3] = 1'b1;
        wait_state(2'd2, 20, "cool_after_zone3");
        wait_state(2'd0, 20, "idle_after_zone3");
        check("no_timeout_yet", 32'(tp_count), 32'd0);

        // zone 2 dry permanently, humid air: dripper timeout and rerun
        air = 1'b1;
        earth = 4'b1011;
        exp_q.push_back('{spk: 4'b0000, drp: 4'b0100, az: 2'd2});
        exp_q.push_back('{spk: 4'b0000, drp: 4'b0100, az: 2'd2});
        tp0 = tp_count;
        wait_act(4'b0000, 4'b0100, 20, "run_zone2");
        n = 0;
        while (zone_dripper === 4'b0100 && n < 40) begin
            tick(1);
            n++;
        end
        check("dripper_len", 32'(n), 32'd16);
        check("tp_once", 32'(tp_count - tp0), 32'd1);
        check("state_after_timeout", 32'(state), 32'd2);
        wait_act(4'b0000, 4'b0100, 20, "rerun_zone2");

        // sensor conflict during the run
        high = 1'b1;
        mid  = 1'b0;
        tick(6);
        check("pre_fault_state", 32'(state), 32'd1);
        tick(1);
        check("fault_state", 32'(state), 32'd3);
        check("fault_zones", 32'(zone_splinker | zone_dripper), 32'd0);
        check("fault_valve", 32'(valve), 32'd0);
        check("fault_alarm", 32'(alarm), 32'd1);
        high = 1'b0;
        tick(9);
        check("fault_hold", 32'(state), 32'd3);
        tick(1);
        check("fault_exit_idle", 32'(state), 32'd0);
        check("low_reserve_alarm", 32'(alarm), 32'd1);
        exp_q.push_back('{spk: 4'b0000, drp: 4'b0100, az: 2'd2});
        wait_act(4'b0000, 4'b0100, 10, "run_after_fault");
        check("valve_open_run", 32'(valve), 32'd1);

        // one-cycle reset in the middle of a run
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check("rst2_zones", 32'(zone_splinker | zone_dripper), 32'd0);
        check("rst2_state", 32'(state), 32'd0);
        check("rst2_az", 32'(active_zone), 32'd3);
        check("rst2_valve", 32'(valve), 32'd0);
        check("rst2_alarm", 32'(alarm), 32'd0);
        check("rst2_tp", 32'(timeout_pulse), 32'd0);
        earth = 4'b1110;
        low = 1'b1; mid = 1'b1; high = 1'b0; air = 1'b1;
        exp_q.push_back('{spk: 4'b0000, drp: 4'b0001, az: 2'd0});

        // glitch on zone 0 soil sensor while it runs
        wait_act(4'b0000, 4'b0001, 20, "run_zone0");
        earth[0] = 1'b1;
        tick(3);
        earth[0] = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (state === 2'd1) n++;
        end
        check("glitch_run_continues", 32'(n), 32'd4);
        check("glitch_act", 32'(zone_dripper), 32'h1);
        tp0 = tp_count;
        earth[0] = 1'b1;
        n = 0;
        while (state === 2'd1 && n < 20) begin
            tick(1);
            n++;
        end
        check("change_ends_run_latency", 32'(n), 32'd7);
        check("change_no_timeout", 32'(tp_count - tp0), 32'd0);

        // low reserve alarm
        earth = 4'hF;
        mid = 1'b0;
        n = 0;
        while (alarm !== 1'b1 && n < 30) begin
            tick(1);
            n++;
        end
        check("alarm_rise", 32'(alarm), 32'd1);
`ifdef ALARM_BLINK_EN
        n = 0;
        while (alarm === 1'b1 && n < 30) begin
            tick(1);
            n++;
        end
        check("blink_high", 32'(n), 32'd8);
        n = 0;
        while (alarm === 1'b0 && n < 30) begin
            tick(1);
            n++;
        end
        check("blink_low", 32'(n), 32'd8);
`else
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (alarm === 1'b1) n++;
        end
        check("alarm_steady", 32'(n), 32'd20);
`endif
        mid = 1'b1;
        tick(10);
        check("alarm_clear", 32'(alarm), 32'd0);
        check("valve_final", 32'(valve), 32'd1);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("tp_total", 32'(tp_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
